data_mem_ctrl: RTL and testbench

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/data_mem_ctrl.sv | 87 ++++++++
 tb/tb_data_mem_ctrl.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: 32-bit data memory controller with byte/half/word loads and stores, wait states and fault detection.
// Ports: clk, rst (async, active-high); request side req/we/size/sign_ext/addr/wdata;
// response side ready (idle), rvalid (one-cycle completion), rdata (load result), err (faulted access).
module data_mem_ctrl #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic        err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_n;
  logic [3:0] cnt;
  logic we_q, sext_q;
  logic [1:0] size_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] mem [DEPTH_WORDS];
  logic accept, commit, a_we, a_sext, fault, unused_bits;
  logic [1:0] a_size;
  logic [31:0] a_addr, a_wdata, word, shifted, load_val, lane_data;
  logic [3:0] be;
  logic [AW-1:0] idx;
  // With no wait states the array is accessed on the accepting edge itself,
  // so the live inputs are used in IDLE and the latched copies afterwards.
  always_comb begin
    accept = state == IDLE && req;
    commit = (accept && WAIT_CYCLES == 0) || (state == WAIT && cnt == 4'd1);
    state_n = commit ? RESP : accept ? WAIT : state == RESP ? IDLE : state;
    ready = state == IDLE;
    rvalid = state == RESP;
    a_we = state == IDLE ? we : we_q;
    a_size = state == IDLE ? size : size_q;
    a_sext = state == IDLE ? sign_ext : sext_q;
    a_addr = state == IDLE ? addr : addr_q;
    a_wdata = state == IDLE ? wdata : wdata_q;
    idx = a_addr[AW+1:2];
    unused_bits = ^a_addr[31:AW+2];
    fault = a_size == 2'd3 || (a_size == 2'd1 && a_addr[0]) || (a_size == 2'd2 && a_addr[1:0] != 2'd0);
    be = a_size == 2'd2 ? 4'hF : a_size == 2'd1 ? (a_addr[1] ? 4'hC : 4'h3) : 4'b0001 << a_addr[1:0];
    lane_data = a_size == 2'd0 ? {4{a_wdata[7:0]}} : a_size == 2'd1 ? {2{a_wdata[15:0]}} : a_wdata;
    word = mem[idx];
    shifted = word >> {a_addr[1:0], 3'b000};
    load_val = a_size == 2'd0 ? {{24{a_sext & shifted[7]}}, shifted[7:0]} :
               a_size == 2'd1 ? {{16{a_sext & shifted[15]}}, shifted[15:0]} : word;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= 4'd0;
      we_q <= 1'b0;
      sext_q <= 1'b0;
      size_q <= 2'd0;
      addr_q <= 32'd0;
      wdata_q <= 32'd0;
      rdata <= 32'd0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= accept ? 4'(WAIT_CYCLES) : state == WAIT ? cnt - 4'd1 : cnt;
      if (accept) begin
        we_q <= we;
        sext_q <= sign_ext;
        size_q <= size;
        addr_q <= addr;
        wdata_q <= wdata;
      end
      rdata <= commit && !a_we && !fault ? load_val : 32'd0;
      err <= commit && fault;
    end
  end
  // Array is deliberately not reset so contents survive rst.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (commit && a_we && !fault && be[i]) mem[idx][8*i +: 8] <= lane_data[8*i +: 8];
  end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: randomized self-checking bench for data_mem_ctrl with a byte-level reference model.
module tb_data_mem_ctrl;
  logic clk = 0, rst = 0;
  logic req [2], we [2], sign_ext [2], ready [2], rvalid [2], err [2];
  logic [1:0] size [2];
  logic [31:0] addr [2], wdata [2], rdata [2];
  logic [7:0] mdl [2][4096];
  int total = 0, bad = 0;
  logic [31:0] got;
  always #5 clk = ~clk;
  data_mem_ctrl #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u0 (
    .clk(clk), .rst(rst), .req(req[0]), .we(we[0]), .size(size[0]), .sign_ext(sign_ext[0]),
    .addr(addr[0]), .wdata(wdata[0]), .ready(ready[0]), .rvalid(rvalid[0]), .rdata(rdata[0]), .err(err[0]));
  data_mem_ctrl #(.DEPTH_WORDS(1024), .WAIT_CYCLES(3)) u1 (
    .clk(clk), .rst(rst), .req(req[1]), .we(we[1]), .size(size[1]), .sign_ext(sign_ext[1]),
    .addr(addr[1]), .wdata(wdata[1]), .ready(ready[1]), .rvalid(rvalid[1]), .rdata(rdata[1]), .err(err[1]));
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask
  function automatic bit is_fault(input logic [1:0] sz, input logic [31:0] a);
    return sz == 2'd3 || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
  endfunction
  function automatic int nbytes(input logic [1:0] sz);
    return sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
  endfunction
  function automatic logic [31:0] ref_load(input int s, input logic [1:0] sz, input logic sx, input logic [31:0] a);
    logic [31:0] v = 32'd0;
    int nb = nbytes(sz);
    for (int k = 0; k < nb; k++) v[8*k +: 8] = mdl[s][int'((a + 32'(k)) & 32'hFFF)];
    if (sx && nb < 4 && v[8*nb-1]) for (int k = nb; k < 4; k++) v[8*k +: 8] = 8'hFF;
    return v;
  endfunction
  task automatic ref_store(input int s, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    for (int k = 0; k < nbytes(sz); k++) mdl[s][int'((a + 32'(k)) & 32'hFFF)] = wd[8*k +: 8];
  endtask
  task automatic acc(input int s, input logic w, input logic [1:0] sz, input logic sx,
                     input logic [31:0] a, input logic [31:0] wd, input bit hold, output logic [31:0] res);
    int n = 0;
    bit exp_e;
    logic [31:0] exp_d;
    @(negedge clk);
    check("ready_idle", 32'(ready[s]), 32'd1);
    req[s] = 1; we[s] = w; size[s] = sz; sign_ext[s] = sx; addr[s] = a; wdata[s] = wd;
    @(posedge clk);
    #1;
    if (!hold) req[s] = 0;
    we[s] = 1'($urandom); size[s] = 2'($urandom); sign_ext[s] = 1'($urandom);
    addr[s] = $urandom; wdata[s] = $urandom;
    do begin
      @(negedge clk);
      n++;
    end while (!rvalid[s] && n < 20);
    check("latency", 32'(n), s == 0 ? 32'd1 : 32'd4);
    exp_e = is_fault(sz, a);
    exp_d = (w || exp_e) ? 32'd0 : ref_load(s, sz, sx, a);
    if (w && !exp_e) ref_store(s, sz, a, wd);
    check("err", 32'(err[s]), 32'(exp_e));
    check("rdata", rdata[s], exp_d);
    check("ready_busy", 32'(ready[s]), 32'd0);
    res = rdata[s];
    req[s] = 0;
    @(negedge clk);
    check("rvalid_pulse", 32'(rvalid[s]), 32'd0);
  endtask
  initial begin
    for (int s = 0; s < 2; s++) begin
      req[s] = 0; we[s] = 0; size[s] = 0; sign_ext[s] = 0; addr[s] = 0; wdata[s] = 0;
    end
    #2 rst = 1;
    #1;
    for (int s = 0; s < 2; s++) begin
      check("rst_ready", 32'(ready[s]), 32'd1);
      check("rst_rvalid", 32'(rvalid[s]), 32'd0);
      check("rst_err", 32'(err[s]), 32'd0);
      check("rst_rdata", rdata[s], 32'd0);
    end
    repeat (2) @(negedge clk);
    rst = 0;
    for (int s = 0; s < 2; s++)
      for (int w = 0; w < 16; w++) acc(s, 1, 2'd2, 0, 32'(w * 4), $urandom, 0, got);
    acc(0, 1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 0, got);
    acc(0, 0, 2'd2, 0, 32'h10, 32'h0, 0, got);
    check("lw_10", got, 32'hDEADBEEF);
    acc(0, 1, 2'd0, 0, 32'h13, 32'h000000A5, 0, got);
    acc(0, 0, 2'd0, 1, 32'h13, 32'h0, 0, got);
    check("lb_13", got, 32'hFFFFFFA5);
    acc(0, 0, 2'd0, 0, 32'h13, 32'h0, 0, got);
    check("lbu_13", got, 32'h000000A5);
    acc(0, 0, 2'd2, 0, 32'h10, 32'h0, 0, got);
    check("lw_10_sb", got, 32'hA5ADBEEF);
    acc(0, 0, 2'd1, 0, 32'h11, 32'h0, 0, got);
    check("lh_11_fault", got, 32'h0);
    acc(0, 1, 2'd2, 0, 32'h12, 32'h11112222, 0, got);
    acc(0, 0, 2'd2, 0, 32'h10, 32'h0, 0, got);
    check("lw_10_kept", got, 32'hA5ADBEEF);
    acc(0, 1, 2'd2, 0, 32'h1000, 32'h0000CAFE, 0, got);
    acc(0, 0, 2'd2, 0, 32'h0, 32'h0, 0, got);
    check("wrap", got, 32'h0000CAFE);
    acc(1, 0, 2'd2, 0, 32'h10, 32'h0, 1, got);
    repeat (3) begin
      @(negedge clk);
      check("no_extra", 32'(rvalid[1]), 32'd0);
    end
    @(negedge clk);
    req[1] = 1; we[1] = 1; size[1] = 2'd2; addr[1] = 32'h20; wdata[1] = 32'h12345678;
    @(posedge clk);
    #1 req[1] = 0;
    @(negedge clk);
    rst = 1;
    #1;
    check("abort_ready", 32'(ready[1]), 32'd1);
    check("abort_rvalid", 32'(rvalid[1]), 32'd0);
    check("abort_err", 32'(err[1]), 32'd0);
    check("abort_rdata", rdata[1], 32'd0);
    repeat (2) @(negedge clk);
    rst = 0;
    acc(1, 0, 2'd2, 0, 32'h20, 32'h0, 0, got);
    check("abort_kept", got, {mdl[1][35], mdl[1][34], mdl[1][33], mdl[1][32]});
    @(negedge clk);
    req[0] = 1; we[0] = 1; size[0] = 2'd2; addr[0] = 32'h30; wdata[0] = 32'h0BADF00D;
    @(posedge clk);
    #1 req[0] = 0;
    @(negedge clk);
    check("resp_rvalid", 32'(rvalid[0]), 32'd1);
    rst = 1;
    #1;
    check("trunc_rvalid", 32'(rvalid[0]), 32'd0);
    check("trunc_ready", 32'(ready[0]), 32'd1);
    ref_store(0, 2'd2, 32'h30, 32'h0BADF00D);
    @(negedge clk);
    rst = 0;
    acc(0, 0, 2'd2, 0, 32'h30, 32'h0, 0, got);
    check("resp_commit", got, 32'h0BADF00D);
    for (int i = 0; i < 200; i++)
      acc(int'($urandom_range(1)), 1'($urandom), 2'($urandom), 1'($urandom),
          $urandom & 32'hFFFFF03F, $urandom, 0, got);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
